seg_display_scheduler: RTL
==========================

# seg_display_scheduler

Time-multiplexes one shared 4-bit-code-to-7-segment encoder across the four digits of the game's display. It holds the current display message (dashes, "PLAY", a two-digit number, or a HI/LO hint plus number), converts binary values 0–99 to tens/ones with a sequential subtract-by-ten loop, and scans the digit anodes. It sits between the game FSM, which issues load strobes, and the encoder/anode pins, which receive `code` and `an`.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit is enabled per scan step; minimum 2.
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period; minimum 2.

Ports:
- `clk` input 1: system clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `load` input 1: single-cycle request to replace the display content; accepted only when `busy`=0.
- `mode` input 2: 0 = "----", 1 = "PLAY", 2 = number, 3 = hint+number.
- `value` input 7: binary number for modes 2/3; values >99 are clamped to 99.
- `hint_hi` input 1: in mode 3, 1 = "H1", 0 = "L0".
- `blink_en` input 1: when 1, all anodes are off during the off half of the blink period.
- `busy` output 1: conversion in progress; `load` is ignored while busy.
- `code` output 4: digit code to the shared encoder (0–9 digits, 10 P, 11 L, 12 A, 13 Y, 14 H, 15 dash).
- `an` output 4: active-low digit enables; `an[3]` is the leftmost digit.

## Operation
- Reset: `an`=4'b1111, `code`=4'hF, `busy`=0, scan index=0, scan and blink counters=0, blink phase=on, and committed content = mode 0 ("----").
- Load is accepted when `load`=1 and `busy`=0. On acceptance, the block captures `mode`, `hint_hi`, and min(`value`,99) into `rem`, sets `tens`=0, and raises `busy` on the next cycle.
- Each busy cycle:
  - If `rem`≥10: `rem`-=10 and `tens`+=1.
  - Otherwise: commit mode, hint, `tens`, and `rem` (as ones) to the display registers, and clear `busy`.
- Modes 0 and 1 also pass through one busy cycle so that commit timing is uniform.
- The displayed content changes only at commit, so a half-converted number is never shown.
- Digit contents, left to right (digit 3 to digit 0):
  - mode 0: 15,15,15,15
  - mode 1: 10,11,12,13
  - mode 2: 15,15,tens,ones
  - mode 3 with `hint_hi`=1: 14,1,tens,ones
  - mode 3 with `hint_hi`=0: 11,0,tens,ones
- Scan:
  - The scan counter runs 0..SCAN_DIV-1. On wrap, the index advances 0→1→2→3→0.
  - Index i drives `an` = all ones except bit i=0, and `code` = content of digit i.
- Blink:
  - The blink counter runs continuously and toggles the phase on wrap.
  - While `blink_en`=1 and the phase is off, `an`=4'b1111. `code` keeps scanning.
  - Deasserting `blink_en` restores `an` on the next cycle.
- A `load` arriving in the same cycle as the final busy cycle is ignored, because `busy` is still 1.
- Reset asserted mid-conversion aborts the conversion and restores the reset content.

## Timing
- `code` and `an` are registered and change in the same cycle, one cycle after the index update, so they never disagree.
- Load-to-commit latency: `busy` is high for tens+1 cycles, where tens is computed from the clamped value. Value 0 gives 1 cycle; value 99 gives 10 cycles.
- New content appears on `code` at the first register update after commit, for whichever digit is currently scanned.
- A full scan period is 4·SCAN_DIV cycles.
- The first index advance occurs SCAN_DIV cycles after reset release.

## Structure
- The shared package holds the symbol codes (CODE_P=10, CODE_L=11, CODE_A=12, CODE_Y=13, CODE_H=14, CODE_DASH=15) and the mode encodings. The game FSM and the encoder side share these.
- One natural sub-module, `bin2bcd_seq`, contains the subtract-by-ten converter with start/busy/done. The scan, blink, and digit mux stay in the top level.
- The encoder itself is instantiated outside this block.

## Test plan
Use SCAN_DIV=4 and BLINK_DIV=16 throughout.
- Reset, then run 16 cycles → `an` steps 1110,1101,1011,0111 every 4 cycles; `code` = 15 on every digit; `busy`=0.
- Load mode 2 with value 47 → `busy` high for exactly 5 cycles; afterwards digits 0/1 show 7/4 and digits 2/3 show 15.
- Load mode 3 with `hint_hi`=0 and value 120 → clamped to 99; `busy` high for 10 cycles; digits 3..0 = 11,0,9,9.
- Assert `load` with value 5 while `busy`=1, including on the final busy cycle → request ignored; committed content unchanged from the accepted load.
- Load mode 1, then set `blink_en`=1 → `an`=1111 for 16 cycles, then scanning for 16 cycles, repeating; `code` during the on phase = 10,11,12,13 by digit.
- Assert `rst` on the 3rd busy cycle of a value-80 conversion → next cycle `busy`=0, `an`=1111, `code`=15; content is "----".

Source files
------------

// File: rtl/seg_display_scheduler_pkg.sv
// Shared display symbols and message modes for the game FSM, this scheduler
// and the 7-segment encoder.
package seg_display_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_DASH = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_NUM  = 2'd2,
    MODE_HINT = 2'd3
  } mode_t;

  localparam logic [3:0] CODE_P    = 4'd10;
  localparam logic [3:0] CODE_L    = 4'd11;
  localparam logic [3:0] CODE_A    = 4'd12;
  localparam logic [3:0] CODE_Y    = 4'd13;
  localparam logic [3:0] CODE_H    = 4'd14;
  localparam logic [3:0] CODE_DASH = 4'd15;

  localparam logic [6:0] VALUE_MAX = 7'd99;

  // Digit idx (0 = rightmost) of the message described by mode/hint/tens/ones.
  function automatic logic [3:0] digit_code(input mode_t      mode,
                                            input logic       hint_hi,
                                            input logic [3:0] tens,
                                            input logic [3:0] ones,
                                            input logic [1:0] idx);
    logic [15:0] digits;
    case (mode)
      MODE_DASH: digits = {4{CODE_DASH}};
      MODE_PLAY: digits = {CODE_P, CODE_L, CODE_A, CODE_Y};
      MODE_NUM:  digits = {CODE_DASH, CODE_DASH, tens, ones};
      default:   digits = hint_hi ? {CODE_H, 4'd1, tens, ones}
                                  : {CODE_L, 4'd0, tens, ones};
    endcase
    return digits[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_display_scheduler_bin2bcd_seq.sv
// Sequential 0..99 binary to tens/ones converter: one subtract-by-ten per cycle.
// done is high during the final busy cycle, while tens/ones already hold the result.
import seg_display_scheduler_pkg::*;

module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] rem;
  logic [3:0] tens_q;
  logic       busy_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      rem    <= 7'd0;
      tens_q <= 4'd0;
    end else if (!busy_q) begin
      if (start) begin
        rem    <= (value > VALUE_MAX) ? VALUE_MAX : value;
        tens_q <= 4'd0;
        busy_q <= 1'b1;
      end
    end else if (rem >= 7'd10) begin
      rem    <= rem - 7'd10;
      tens_q <= tens_q + 4'd1;
    end else begin
      busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (rem < 7'd10);
  assign tens = tens_q;
  assign ones = rem[3:0];

endmodule

// File: rtl/seg_display_scheduler.sv
// Four-digit multiplexed display scheduler: holds the committed message,
// scans the anodes through one shared encoder code and blinks on request.
import seg_display_scheduler_pkg::*;

module seg_display_scheduler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] mode,
  input  logic [6:0] value,
  input  logic       hint_hi,
  input  logic       blink_en,
  output logic       busy,
  output logic [3:0] code,
  output logic [3:0] an
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic               accept;
  logic               conv_done;
  logic [3:0]         conv_tens;
  logic [3:0]         conv_ones;
  mode_t              pend_mode;
  logic               pend_hint;
  mode_t              disp_mode;
  logic               disp_hint;
  logic [3:0]         disp_tens;
  logic [3:0]         disp_ones;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [3:0]         code_next;
  logic [3:0]         an_next;

  assign accept = load && !busy;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .value (value),
    .busy  (busy),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Mode and hint wait alongside the conversion so the whole message commits at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mode <= MODE_DASH;
      pend_hint <= 1'b0;
      disp_mode <= MODE_DASH;
      disp_hint <= 1'b0;
      disp_tens <= 4'd0;
      disp_ones <= 4'd0;
    end else begin
      if (accept) begin
        pend_mode <= mode_t'(mode);
        pend_hint <= hint_hi;
      end
      if (conv_done) begin
        disp_mode <= pend_mode;
        disp_hint <= pend_hint;
        disp_tens <= conv_tens;
        disp_ones <= conv_ones;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_idx  <= 2'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    code_next = digit_code(disp_mode, disp_hint, disp_tens, disp_ones, scan_idx);
    an_next   = ~(4'b0001 << scan_idx);
    if (blink_en && !blink_on) an_next = 4'b1111;
  end

  // code and an share one register stage so they always describe the same digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      code <= CODE_DASH;
      an   <= 4'b1111;
    end else begin
      code <= code_next;
      an   <= an_next;
    end
  end

endmodule
